// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath width, one-hot ALU bit indices and branch funct3 codes
package riscv_pkg;
    localparam int XLEN    = 32;
    localparam int ACTRL_W = 10;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLL  = 2;
    localparam int ALU_SLT  = 3;
    localparam int ALU_SLTU = 4;
    localparam int ALU_XOR  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_OR   = 8;
    localparam int ALU_AND  = 9;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-to-EX valid/ready handshake plus the decoded instruction payload
interface id_ex_stage_if #(
    parameter int XLEN    = 32,
    parameter int ACTRL_W = 10
);
    logic               id_valid;
    logic               id_ready;
    logic [XLEN-1:0]    id_pc;
    logic [XLEN-1:0]    id_rs1_data;
    logic [XLEN-1:0]    id_rs2_data;
    logic [XLEN-1:0]    id_imm;
    logic [4:0]         id_rs1;
    logic [4:0]         id_rs2;
    logic [4:0]         id_rd;
    logic [ACTRL_W-1:0] id_alu_ctrl;
    logic [2:0]         id_bropcode;
    logic               id_use_imm;
    logic               id_is_branch;
    logic               id_reg_write;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_alu_ctrl, id_bropcode, id_use_imm, id_is_branch, id_reg_write,
        input  id_ready
    );
    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_alu_ctrl, id_bropcode, id_use_imm, id_is_branch, id_reg_write,
        output id_ready
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: operand bypass from MEM/WB onto a registered source operand
// Bypass paths exist only when ID_EX_FWD_EN is defined.
module fwd_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      r,
    input  logic [XLEN-1:0] reg_data,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] data
);
`ifdef ID_EX_FWD_EN
    // MEM is younger than WB, so it wins when both target the same register
    assign data = (mem_reg_write && mem_rd == r && r != 5'd0) ? mem_result :
                  (wb_reg_write && wb_rd == r && r != 5'd0)   ? wb_result  : reg_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{r, mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result};
    assign data = reg_data;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with flush, stall accounting and operand forwarding
// ID_EX_FWD_EN selects MEM/WB forwarding; otherwise decode stalls on RAW hazards.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = riscv_pkg::XLEN,
    parameter int ACTRL_W = riscv_pkg::ACTRL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    id_ex_stage_if.slave       id,
    input  logic               flush,
    input  logic               ex_ready,
    input  logic [4:0]         mem_rd,
    input  logic               mem_reg_write,
    input  logic [XLEN-1:0]    mem_result,
    input  logic [4:0]         wb_rd,
    input  logic               wb_reg_write,
    input  logic [XLEN-1:0]    wb_result,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_a,
    output logic [XLEN-1:0]    ex_b,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [XLEN-1:0]    ex_pc,
    output logic [ACTRL_W-1:0] ex_alu_ctrl,
    output logic [2:0]         ex_bropcode,
    output logic               ex_is_branch,
    output logic               ex_reg_write,
    output logic               ex_illegal,
    output logic [4:0]         ex_rd,
    output logic [15:0]        stall_cnt
);
    logic [XLEN-1:0]    rs1_data_q, rs2_data_q, imm_q, fwd1, fwd2;
    logic [4:0]         rs1_q, rs2_q;
    logic [ACTRL_W-1:0] alu_q;
    logic               use_imm_q, br_q, rw_q;
    logic               hazard, advance, capture;

`ifdef ID_EX_FWD_EN
    assign hazard = 1'b0;
`else
    logic dep1, dep2;
    assign dep1 = id.id_rs1 != 5'd0 && ((ex_valid && rw_q && ex_rd == id.id_rs1) ||
                  (mem_reg_write && mem_rd == id.id_rs1) || (wb_reg_write && wb_rd == id.id_rs1));
    assign dep2 = id.id_rs2 != 5'd0 && ((ex_valid && rw_q && ex_rd == id.id_rs2) ||
                  (mem_reg_write && mem_rd == id.id_rs2) || (wb_reg_write && wb_rd == id.id_rs2));
    assign hazard = id.id_valid && (dep1 || dep2);
`endif

    // The EX slot refills whenever it is empty or its occupant moves on
    assign advance     = !ex_valid || ex_ready;
    assign id.id_ready = advance && !hazard;
    assign capture     = id.id_valid && id.id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rd       <= '0;
            ex_bropcode <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_q       <= '0;
            use_imm_q   <= 1'b0;
            br_q        <= 1'b0;
            rw_q        <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (id.id_valid && !id.id_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush) begin
                ex_valid <= 1'b0;
                rw_q     <= 1'b0;
                alu_q    <= '0;
                br_q     <= 1'b0;
            end else if (advance) begin
                ex_valid <= capture;
                if (capture) begin
                    ex_pc       <= id.id_pc;
                    ex_rd       <= id.id_rd;
                    ex_bropcode <= id.id_bropcode;
                    rs1_q       <= id.id_rs1;
                    rs2_q       <= id.id_rs2;
                    rs1_data_q  <= (id.id_rs1 == 5'd0) ? '0 : id.id_rs1_data;
                    rs2_data_q  <= (id.id_rs2 == 5'd0) ? '0 : id.id_rs2_data;
                    imm_q       <= id.id_imm;
                    alu_q       <= id.id_alu_ctrl;
                    use_imm_q   <= id.id_use_imm;
                    br_q        <= id.id_is_branch;
                    rw_q        <= id.id_reg_write;
                end
            end
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .r(rs1_q), .reg_data(rs1_data_q),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .data(fwd1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .r(rs2_q), .reg_data(rs2_data_q),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .data(fwd2)
    );

    // An empty slot must look like a NOP downstream: no ALU op, no writeback, no branch
    assign ex_alu_ctrl   = ex_valid ? alu_q : '0;
    assign ex_reg_write  = ex_valid && rw_q;
    assign ex_is_branch  = ex_valid && br_q;
    assign ex_illegal    = ex_valid && ($countones(alu_q) != 1) && !(br_q && alu_q == '0);
    assign ex_a          = fwd1;
    assign ex_store_data = fwd2;
    assign ex_b          = br_q ? fwd2 : (use_imm_q ? imm_q : fwd2);
endmodule
